// File: rtl/clock_set_ctrl_pkg.sv
// Shared state codes, field encoding and helpers for the clock time-setting controller.
// The datapath and display logic decode `field` using the same state codes.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HRS = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_e;

  localparam int NUM_BTN  = 2;
  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;

  typedef struct packed {
    logic hrs;
    logic min;
    logic sec;
  } fld_t;

  function automatic state_e next_state(input state_e s);
    case (s)
      ST_RUN:     next_state = ST_SET_HRS;
      ST_SET_HRS: next_state = ST_SET_MIN;
      ST_SET_MIN: next_state = ST_SET_SEC;
      default:    next_state = ST_RUN;
    endcase
  endfunction

  // One-hot field select for the state being set; all zero in RUN.
  function automatic fld_t field_sel(input state_e s);
    field_sel = '0;
    case (s)
      ST_SET_HRS: field_sel.hrs = 1'b1;
      ST_SET_MIN: field_sel.min = 1'b1;
      ST_SET_SEC: field_sel.sec = 1'b1;
      default:    field_sel = '0;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_frame_debounce.sv
// Button conditioner: 2-flop synchroniser, then a debounce that only samples on frame_tick.
// lvl is the debounced level as it will be after this cycle; rise flags an accepted 0->1 edge.
module frame_debounce #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic btn,
  output logic lvl,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          differ;
  logic          accept;

  assign differ = sync_q[1] ^ level_q;
  assign accept = frame_tick && differ && (cnt_q >= CNT_LAST);
  assign lvl    = accept ? sync_q[1] : level_q;
  assign rise   = accept && sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (frame_tick) begin
        // Any frame sample matching the current level restarts the run.
        if (accept) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else if (differ) begin
          cnt_q <= cnt_q + CW'(1);
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// MODE/INC time-setting controller: field sequencer, adj pulses with auto-repeat,
// idle timeout back to RUN, and a frame-synchronous blink mask for the field being set.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY    = 24,
  parameter int REPEAT_RATE     = 6,
  parameter int BLINK_FRAMES    = 32,
  parameter int IDLE_TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       adj_hrs,
  output logic       adj_min,
  output logic       adj_sec,
  output logic       setting,
  output logic [1:0] field,
  output logic       blank_hrs,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [RW-1:0] RPT_FIRST_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [IW-1:0] IDLE_LAST      = IW'(IDLE_TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST     = BW'(BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_HALF     = BW'(BLINK_FRAMES / 2);

  logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_rise;
  logic               unused_mode_lvl;

  assign btn_raw = {btn_inc, btn_mode};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .btn        (btn_raw[i]),
      .lvl        (btn_lvl[i]),
      .rise       (btn_rise[i])
    );
  end

  assign unused_mode_lvl = btn_lvl[BTN_MODE];

  state_e        state_q, state_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          rpt_first_q, rpt_first_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          mask_q, mask_d;
  fld_t          adj_q, adj_d;
  fld_t          blank_q, blank_d;
  logic          setting_q, setting_d;

  logic inc_held, mode_press, inc_press;

  assign inc_held   = btn_lvl[BTN_INC];
  assign mode_press = btn_rise[BTN_MODE];
  // MODE wins a same-tick race; a masked INC needs a fresh release/press.
  assign inc_press  = btn_rise[BTN_INC] && !mode_press && !mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
      idle_q      <= '0;
      blink_q     <= '0;
      mask_q      <= 1'b0;
      adj_q       <= '0;
      blank_q     <= '0;
      setting_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
      idle_q      <= idle_d;
      blink_q     <= blink_d;
      mask_q      <= mask_d;
      adj_q       <= adj_d;
      blank_q     <= blank_d;
      setting_q   <= setting_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    idle_d      = idle_q;
    blink_d     = blink_q;
    mask_d      = mask_q;
    adj_d       = '0;
    blank_d     = blank_q;
    setting_d   = setting_q;

    if (frame_tick) begin
      blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BW'(1);

      if (mode_press && inc_held) mask_d = 1'b1;
      else if (!inc_held)         mask_d = 1'b0;

      if (mode_press) begin
        state_d     = next_state(state_q);
        idle_d      = '0;
        rpt_d       = '0;
        rpt_first_d = 1'b1;
      end else if (state_q == ST_RUN) begin
        idle_d      = '0;
        rpt_d       = '0;
        rpt_first_d = 1'b1;
      end else if (inc_press) begin
        adj_d       = field_sel(state_q);
        idle_d      = '0;
        rpt_d       = '0;
        rpt_first_d = 1'b1;
      end else if (inc_held) begin
        idle_d = '0;
        if (!mask_q) begin
          // First repeat after REPEAT_DELAY frames, then every REPEAT_RATE.
          if (rpt_q >= (rpt_first_q ? RPT_FIRST_LAST : RPT_NEXT_LAST)) begin
            adj_d       = field_sel(state_q);
            rpt_d       = '0;
            rpt_first_d = 1'b0;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
        end
      end else begin
        rpt_d       = '0;
        rpt_first_d = 1'b1;
        if (idle_q >= IDLE_LAST) begin
          state_d = ST_RUN;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end

      setting_d = (state_d != ST_RUN);
      blank_d   = (!inc_held && (blink_d >= BLINK_HALF)) ? field_sel(state_d) : '0;
    end
  end

  assign adj_hrs   = adj_q.hrs;
  assign adj_min   = adj_q.min;
  assign adj_sec   = adj_q.sec;
  assign blank_hrs = blank_q.hrs;
  assign blank_min = blank_q.min;
  assign blank_sec = blank_q.sec;
  assign setting   = setting_q;
  assign field     = state_q;

endmodule
